parity_frame_sched: RTL and testbench
=====================================

# parity_frame_sched

Two-requester scheduler and sequencer for the bit-serial parity checker. Accepts byte frames plus a parity mode from two clients, arbitrates round-robin, and serialises each byte MSB-first into the checker's data_in/valid/mode inputs. It pulses a per-frame checker clear, samples parity_ok after a fixed latency, and returns a tagged result with valid/ready backpressure. It also keeps a saturating count of failed frames.

## Interface
- RESULT_LAT, 1: cycles between the last serial bit and sampling of chk_parity_ok; legal range 1..7.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  2  per-requester frame valid; bit i is requester i.
- req_data0  in  8  frame byte, requester 0.
- req_data1  in  8  frame byte, requester 1.
- req_mode  in  2  parity mode per requester: 0 = even, 1 = odd.
- req_ready  out  2  per-requester accept strobe.
- chk_clear  out  1  one-cycle clear to the checker, wired into its reset.
- chk_data  out  1  serial bit to the checker's data_in.
- chk_valid  out  1  to the checker's valid.
- chk_mode  out  1  to the checker's mode.
- chk_parity_ok  in  1  from the checker's parity_ok.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_id  out  1  requester index of the result.
- res_ok  out  1  sampled parity_ok.
- err_cnt  out  8  saturating count of frames with res_ok = 0.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SHIFT, WAIT, REPORT.
- **IDLE**
  - If any req_valid bit is set, grant one requester by round-robin.
  - Priority goes to the requester not granted last; the last-grant register resets to 1, so requester 0 wins first.
  - req_ready[g] = 1 combinationally for the granted g only; accept = req_valid[g] & req_ready[g].
  - On accept: chk_clear = 1 in that same cycle.
  - On the clock edge: load the shift register with the byte, latch the mode and id, update last-grant, go to SHIFT.
- **SHIFT** (exactly 8 cycles)
  - chk_valid = 1, chk_data = shreg[7]; shift left every cycle.
  - A 3-bit counter runs 0..7; go to WAIT after count 7.
- **WAIT** (RESULT_LAT cycles)
  - chk_valid = 0, chk_data = 0.
  - On the edge ending the last WAIT cycle, capture res_ok = chk_parity_ok.
  - On that same edge, increment err_cnt if chk_parity_ok = 0, saturating at 255. Go to REPORT.
- **REPORT**
  - res_valid = 1, with res_id and res_ok held stable until res_valid & res_ready.
  - On that handshake edge go to IDLE.
  - req_ready = 0 throughout REPORT (no overlap of frames).
- chk_mode holds the latched frame mode from SHIFT through REPORT; otherwise it keeps its last value.
- req_ready, chk_clear and chk_valid are 0 outside the states above.
- Requests that are not accepted are not dropped; requesters hold req_valid and data until they see req_ready.

## Timing
- Reset values: state IDLE, req_ready 0, chk_clear 0, chk_data 0, chk_valid 0, chk_mode 0, res_valid 0, res_id 0, res_ok 0, err_cnt 0, busy 0, last-grant 1.
- Reset mid-frame: outputs go to reset values immediately (asynchronously). The in-flight frame is lost and no result is produced.
- Cycle numbering: the accept cycle is cycle 0.
  - Bit 7 of the byte is on chk_data in cycle 1; bit 0 is in cycle 8.
  - WAIT occupies cycles 9..8+RESULT_LAT.
  - res_valid rises in cycle 9+RESULT_LAT, i.e. cycle 10 for the default.
- Throughput: with res_ready tied high, the minimum frame period is 10+RESULT_LAT cycles (11 for the default).
- Simultaneous requests in IDLE: exactly one grant, per round-robin. With both requesters continuously valid, grants strictly alternate.
- err_cnt at 255 with another failing frame: stays 255.

## Test plan
1. Reset, then req_valid=01, req_data0=0xD1, req_mode=00; the checker model returns ok=1 -> chk_data is 1,1,0,1,0,0,0,1 in cycles 1-8, chk_clear=1 in cycle 0, res_valid in cycle 10 with res_id=0, res_ok=1, err_cnt=0.
2. req_valid=11 held continuously with bytes 0x0F/0xF0, res_ready=1 -> grant order 0,1,0,1; accepts are 11 cycles apart; exactly one req_ready bit high per accept.
3. Checker model forces ok=0 on 257 consecutive frames -> err_cnt reads 1, 2, …, 255, then stays 255; res_ok=0 on every frame.
4. res_ready held low for 5 cycles after res_valid rises -> res_valid, res_id and res_ok stay stable; req_ready stays 00 even with req_valid=11; IDLE is entered the edge after res_ready=1.
5. Assert reset in cycle 4 of a requester-1 frame -> chk_valid, busy and err_cnt are 0 immediately and no result appears; after release with req_valid=11, requester 0 is granted first.
6. RESULT_LAT=3, req_data1=0x01, mode odd -> chk_mode=1 from cycle 1, chk_parity_ok sampled at the end of cycle 11, res_valid rises in cycle 12 with res_id=1.

Source files
------------

// File: rtl/parity_frame_sched_if.sv
// Bundle of the requester, checker and result signals around parity_frame_sched.
// The scheduler sits on the slave modport; requesters, checker and consumer use master.
interface parity_frame_sched_if;
  logic [1:0] req_valid;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_mode;
  logic [1:0] req_ready;
  logic       chk_clear;
  logic       chk_data;
  logic       chk_valid;
  logic       chk_mode;
  logic       chk_parity_ok;
  logic       res_valid;
  logic       res_ready;
  logic       res_id;
  logic       res_ok;
  logic [7:0] err_cnt;
  logic       busy;

  modport slave (
    input  req_valid, req_data0, req_data1, req_mode, chk_parity_ok, res_ready,
    output req_ready, chk_clear, chk_data, chk_valid, chk_mode,
           res_valid, res_id, res_ok, err_cnt, busy
  );

  modport master (
    output req_valid, req_data0, req_data1, req_mode, chk_parity_ok, res_ready,
    input  req_ready, chk_clear, chk_data, chk_valid, chk_mode,
           res_valid, res_id, res_ok, err_cnt, busy
  );
endinterface

// File: rtl/parity_frame_sched.sv
// Round-robin two-requester sequencer that feeds bytes MSB-first into a bit-serial
// parity checker, samples its verdict after RESULT_LAT cycles and returns a tagged result.
//
// state  | meaning
// IDLE   | waiting for a request; grants and clears the checker on accept
// SHIFT  | 8 cycles driving shreg[7] onto chk_data with chk_valid high
// WAIT   | RESULT_LAT cycles of checker latency, parity_ok captured on the last
// REPORT | result held on res_* until res_ready
module parity_frame_sched #(
  parameter int RESULT_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  parity_frame_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(RESULT_LAT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] shreg_q;
  logic [2:0] bit_cnt_q;
  logic [2:0] wait_cnt_q;
  logic       last_grant_q;
  logic       mode_q;
  logic       id_q;
  logic       ok_q;
  logic [7:0] err_cnt_q;

  logic       grant;
  logic       accept;
  logic [1:0] ready;
  logic       chk_data_c;
  logic       chk_valid_c;
  logic       res_valid_c;
  logic       busy_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Both requesting: favour whoever was not served last.
  always_comb begin
    grant = 1'b0;
    if (bus.req_valid == 2'b11) begin
      grant = ~last_grant_q;
    end else if (bus.req_valid[1]) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    ready       = 2'b00;
    chk_data_c  = 1'b0;
    chk_valid_c = 1'b0;
    res_valid_c = 1'b0;
    busy_c      = 1'b1;
    case (state_q)
      IDLE: begin
        busy_c = 1'b0;
        if (|bus.req_valid) begin
          accept  = 1'b1;
          ready   = grant ? 2'b10 : 2'b01;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        chk_valid_c = 1'b1;
        chk_data_c  = shreg_q[7];
        if (bit_cnt_q == 3'd7) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        res_valid_c = 1'b1;
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      wait_cnt_q   <= 3'd0;
      last_grant_q <= 1'b1;
      mode_q       <= 1'b0;
      id_q         <= 1'b0;
      ok_q         <= 1'b0;
      err_cnt_q    <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_q      <= grant ? bus.req_data1 : bus.req_data0;
            mode_q       <= bus.req_mode[grant];
            id_q         <= grant;
            last_grant_q <= grant;
            bit_cnt_q    <= 3'd0;
          end
        end
        SHIFT: begin
          shreg_q   <= {shreg_q[6:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            wait_cnt_q <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (wait_cnt_q == 3'd0) begin
            ok_q <= bus.chk_parity_ok;
            if (!bus.chk_parity_ok && (err_cnt_q != 8'hFF)) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.chk_clear = accept;
  assign bus.chk_data  = chk_data_c;
  assign bus.chk_valid = chk_valid_c;
  assign bus.chk_mode  = mode_q;
  assign bus.res_valid = res_valid_c;
  assign bus.res_id    = id_q;
  assign bus.res_ok    = ok_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.busy      = busy_c;

endmodule

// File: tb/tb_parity_frame_sched.sv
// Directed bench for parity_frame_sched: serial timing, round-robin, error saturation,
// result backpressure, mid-frame reset and a longer checker latency.
module tb_parity_frame_sched;
  logic clk = 1'b0;
  logic reset;
  logic par;
  logic force_bad;
  logic ok3;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  parity_frame_sched_if pfs_if ();
  parity_frame_sched_if pfs3_if ();

  parity_frame_sched #(.RESULT_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (pfs_if.slave)
  );

  parity_frame_sched #(.RESULT_LAT(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (pfs3_if.slave)
  );

  // Checker model: running XOR of accepted bits, verdict against the frame mode.
  always @(posedge clk or posedge reset) begin
    if (reset) par <= 1'b0;
    else if (pfs_if.chk_clear) par <= 1'b0;
    else if (pfs_if.chk_valid) par <= par ^ pfs_if.chk_data;
  end
  assign pfs_if.chk_parity_ok  = force_bad ? 1'b0 : (par == pfs_if.chk_mode);
  assign pfs3_if.chk_parity_ok = ok3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pfs_if.req_valid  = 2'b00;
    pfs_if.req_data0  = 8'h00;
    pfs_if.req_data1  = 8'h00;
    pfs_if.req_mode   = 2'b00;
    pfs_if.res_ready  = 1'b0;
    pfs3_if.req_valid = 2'b00;
    pfs3_if.req_data0 = 8'h00;
    pfs3_if.req_data1 = 8'h00;
    pfs3_if.req_mode  = 2'b00;
    pfs3_if.res_ready = 1'b0;
    force_bad = 1'b0;
    ok3       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_res(input int budget);
    int n = 0;
    while (!pfs_if.res_valid && n < budget) begin
      step();
      #1;
      n++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (pfs_if.busy && n < budget) begin
      step();
      #1;
      n++;
    end
    check_eq("idle_reached", pfs_if.busy, 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         grants[$];
    int         acc_cyc[$];
    logic       seen;

    // Reset values
    reset = 1'b1;
    idle_inputs();
    #1;
    check_eq("rst_req_ready", pfs_if.req_ready, 0);
    check_eq("rst_chk_clear", pfs_if.chk_clear, 0);
    check_eq("rst_chk_data",  pfs_if.chk_data, 0);
    check_eq("rst_chk_valid", pfs_if.chk_valid, 0);
    check_eq("rst_chk_mode",  pfs_if.chk_mode, 0);
    check_eq("rst_res_valid", pfs_if.res_valid, 0);
    check_eq("rst_res_id",    pfs_if.res_id, 0);
    check_eq("rst_res_ok",    pfs_if.res_ok, 0);
    check_eq("rst_err_cnt",   pfs_if.err_cnt, 0);
    check_eq("rst_busy",      pfs_if.busy, 0);
    step();
    step();
    reset = 1'b0;

    // 1: single even frame 0xD1
    b = 8'hD1;
    pfs_if.req_valid = 2'b01;
    pfs_if.req_data0 = b;
    #1;
    check_eq("t1_req_ready", pfs_if.req_ready, 2'b01);
    check_eq("t1_chk_clear", pfs_if.chk_clear, 1);
    step();
    pfs_if.req_valid = 2'b00;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        step();
        #1;
      end
      check_eq("t1_chk_valid", pfs_if.chk_valid, 1);
      check_eq("t1_chk_data", pfs_if.chk_data, b[7-i]);
    end
    step();
    #1;
    check_eq("t1_c9_chk_valid", pfs_if.chk_valid, 0);
    check_eq("t1_c9_res_valid", pfs_if.res_valid, 0);
    check_eq("t1_c9_busy", pfs_if.busy, 1);
    step();
    #1;
    check_eq("t1_res_valid", pfs_if.res_valid, 1);
    check_eq("t1_res_id", pfs_if.res_id, 0);
    check_eq("t1_res_ok", pfs_if.res_ok, 1);
    check_eq("t1_err_cnt", pfs_if.err_cnt, 0);
    pfs_if.res_ready = 1'b1;
    step();
    #1;
    check_eq("t1_back_idle", pfs_if.busy, 0);

    // 2: both requesters continuously valid
    do_reset();
    pfs_if.req_data0 = 8'h0F;
    pfs_if.req_data1 = 8'hF0;
    pfs_if.res_ready = 1'b1;
    pfs_if.req_valid = 2'b11;
    #1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (pfs_if.req_ready != 2'b00) begin
        check_eq("t2_onehot", $countones(pfs_if.req_ready), 1);
        grants.push_back(int'(pfs_if.req_ready[1]));
        acc_cyc.push_back(cyc);
      end
      if (pfs_if.res_valid) check_eq("t2_res_ok", pfs_if.res_ok, 1);
      step();
      #1;
    end
    pfs_if.req_valid = 2'b00;
    wait_idle(40);
    check_eq("t2_accepts", grants.size(), 4);
    for (int k = 0; k < grants.size() && k < 4; k++) begin
      check_eq("t2_grant", grants[k], k % 2);
      if (k > 0) check_eq("t2_spacing", acc_cyc[k] - acc_cyc[k-1], 11);
    end

    // 3: 257 failing frames, err_cnt saturates
    do_reset();
    force_bad = 1'b1;
    pfs_if.req_data0 = 8'hAA;
    pfs_if.res_ready = 1'b1;
    pfs_if.req_valid = 2'b01;
    #1;
    for (int f = 1; f <= 257; f++) begin
      wait_res(20);
      check_eq("t3_res_seen", pfs_if.res_valid, 1);
      check_eq("t3_err_cnt", pfs_if.err_cnt, (f > 255) ? 255 : f);
      check_eq("t3_res_ok", pfs_if.res_ok, 0);
      step();
      #1;
    end
    pfs_if.req_valid = 2'b00;
    force_bad = 1'b0;
    wait_idle(20);

    // 4: result backpressure
    do_reset();
    force_bad = 1'b1;
    pfs_if.req_data0 = 8'h55;
    pfs_if.req_data1 = 8'h3C;
    pfs_if.req_mode  = 2'b10;
    pfs_if.req_valid = 2'b01;
    #1;
    check_eq("t4_req_ready", pfs_if.req_ready, 2'b01);
    step();
    pfs_if.req_valid = 2'b11;
    #1;
    wait_res(20);
    check_eq("t4_res_seen", pfs_if.res_valid, 1);
    check_eq("t4_err_cnt", pfs_if.err_cnt, 1);
    for (int k = 0; k < 5; k++) begin
      check_eq("t4_hold_valid", pfs_if.res_valid, 1);
      check_eq("t4_hold_id", pfs_if.res_id, 0);
      check_eq("t4_hold_ok", pfs_if.res_ok, 0);
      check_eq("t4_no_ready", pfs_if.req_ready, 2'b00);
      step();
      #1;
    end
    pfs_if.res_ready = 1'b1;
    #1;
    check_eq("t4_valid_at_hs", pfs_if.res_valid, 1);
    step();
    #1;
    check_eq("t4_idle_busy", pfs_if.busy, 0);
    check_eq("t4_rr_grant", pfs_if.req_ready, 2'b10);
    check_eq("t4_clear", pfs_if.chk_clear, 1);

    // 5: reset in cycle 4 of the requester-1 frame just accepted
    step();
    pfs_if.req_valid = 2'b00;
    pfs_if.res_ready = 1'b0;
    force_bad = 1'b0;
    #1;
    check_eq("t5_c1_valid", pfs_if.chk_valid, 1);
    check_eq("t5_c1_mode", pfs_if.chk_mode, 1);
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    check_eq("t5_chk_valid", pfs_if.chk_valid, 0);
    check_eq("t5_busy", pfs_if.busy, 0);
    check_eq("t5_err_cnt", pfs_if.err_cnt, 0);
    check_eq("t5_chk_mode", pfs_if.chk_mode, 0);
    step();
    step();
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      #1;
      seen |= pfs_if.res_valid;
      step();
    end
    check_eq("t5_no_result", seen, 0);
    pfs_if.req_valid = 2'b11;
    #1;
    check_eq("t5_first_grant", pfs_if.req_ready, 2'b01);
    pfs_if.req_valid = 2'b00;
    #1;

    // 6: RESULT_LAT = 3, odd frame 0x01 from requester 1
    do_reset();
    pfs3_if.req_data1 = 8'h01;
    pfs3_if.req_mode  = 2'b10;
    pfs3_if.req_valid = 2'b10;
    #1;
    check_eq("t6_req_ready", pfs3_if.req_ready, 2'b10);
    check_eq("t6_clear", pfs3_if.chk_clear, 1);
    check_eq("t6_c0_mode", pfs3_if.chk_mode, 0);
    step();
    pfs3_if.req_valid = 2'b00;
    #1;
    check_eq("t6_c1_mode", pfs3_if.chk_mode, 1);
    check_eq("t6_c1_valid", pfs3_if.chk_valid, 1);
    check_eq("t6_c1_data", pfs3_if.chk_data, 0);
    for (int c = 2; c <= 8; c++) begin
      step();
      #1;
    end
    check_eq("t6_c8_data", pfs3_if.chk_data, 1);
    for (int c = 9; c <= 10; c++) begin
      step();
      #1;
      check_eq("t6_wait_valid", pfs3_if.chk_valid, 0);
      check_eq("t6_wait_res", pfs3_if.res_valid, 0);
    end
    step();
    ok3 = 1'b1;
    #1;
    check_eq("t6_c11_res", pfs3_if.res_valid, 0);
    check_eq("t6_c11_busy", pfs3_if.busy, 1);
    step();
    ok3 = 1'b0;
    #1;
    check_eq("t6_res_valid", pfs3_if.res_valid, 1);
    check_eq("t6_res_id", pfs3_if.res_id, 1);
    check_eq("t6_res_ok", pfs3_if.res_ok, 1);
    check_eq("t6_mode_held", pfs3_if.chk_mode, 1);
    check_eq("t6_err_cnt", pfs3_if.err_cnt, 0);
    pfs3_if.res_ready = 1'b1;
    step();
    #1;
    check_eq("t6_idle", pfs3_if.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
